sha256_digest_collector: RTL and testbench
==========================================

Name: sha256_digest_collector

Overview:
Host-side receiver for the SHA-256 ASIC's 16-bit hash output stream. It captures 16 consecutive 16-bit words, most significant first, and assembles the 256-bit digest. It can optionally compare the digest against an expected value. It flags inter-word timeouts and overruns so the bench and board-level glue can detect a stalled or misbehaving output handler.

Parameters:
WORDS, 16, number of words per digest
WORD_W, 16, width of each output word in bits
TIMEOUT_CYCLES, 64, maximum idle cycles allowed between words once collection has started

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
word_valid  input  1  one-cycle strobe; word_data is valid this cycle
word_data  input  16  hash word, first word is digest[255:240]
compare_enable  input  1  level; enables the expected-digest check
expected_digest  input  256  reference digest; sampled on the edge that captures the last word
clear  input  1  synchronous return to IDLE; clears all flags and digest
digest  output  256  assembled digest
digest_valid  output  1  high while in DONE
match  output  1  compare result; meaningful only while digest_valid=1
busy  output  1  high while in COLLECT
word_count  output  5  number of words captured so far (0..16)
timeout_error  output  1  sticky; set on inter-word timeout
overrun_error  output  1  sticky; set if word_valid arrives in DONE or ERROR

Behaviour:
- Reset:
  - Asynchronous, active-high; one clock, rising-edge logic only.
  - Every output is 0 during and after reset. FSM=IDLE, gap counter=0.
  - Reset asserted mid-collection discards all partial data.
- FSM states: IDLE, COLLECT, DONE, ERROR.
- IDLE:
  - On word_valid: digest <= {digest[239:0], word_data}, word_count=1, go to COLLECT.
  - With WORDS=1 the first word goes straight to DONE instead.
- COLLECT:
  - Each word_valid shifts a word in left-to-right (MSB first), increments word_count and zeroes the gap counter.
  - On a cycle without word_valid, the gap counter increments.
  - When the gap counter reaches TIMEOUT_CYCLES-1 with no word_valid that cycle, go to ERROR on the next edge and set timeout_error.
  - When the WORDS-th word is captured, go to DONE on that same edge. That edge also registers match = compare_enable & (assembled digest == expected_digest).
  - Latency: digest_valid rises the cycle after the final word_valid.
- DONE:
  - digest_valid=1; digest and match are held.
  - word_valid sets overrun_error; the data is ignored and the digest is not modified.
  - DONE is left only via clear or reset.
- ERROR:
  - digest_valid=0; the partial digest and word_count stay visible for debug.
  - word_valid sets overrun_error.
  - ERROR is left only via clear or reset.
- clear:
  - In any state, on the next edge: IDLE, digest=0, word_count=0, all flags=0.
  - clear wins over a simultaneous word_valid; that word is dropped.
- Other rules:
  - word_valid in IDLE together with a held compare_enable is a normal start; compare_enable matters only on the final capture edge.
  - Gap counter width is clog2(TIMEOUT_CYCLES)+1 and saturates; it never wraps.
  - word_count never exceeds WORDS.
  - match is 0 whenever compare_enable was 0 on the final capture edge.

Decomposition:
- Shared package sha256_pkg:
  - FSM state encoding localparams (IDLE, COLLECT, DONE, ERROR).
  - DIGEST_W=256.
  - SHA-256 test vectors ("abc" digest and empty-string digest), for reuse by bench and other host blocks.
- One sub-module: sha256_word_shifter, a WORDS×WORD_W shift register with load-enable and clear.
  - Its output drives digest; the FSM, gap counter and compare stay in the top.

Test Plan:
1. Clean capture: 16 back-to-back strobes carrying ba78,16bf,8f01,cfea,4141,40de,5dae,2223,b003,61a3,9617,7a9c,b410,ff61,f200,15ad with compare_enable=1 and expected = the "abc" digest -> next cycle digest_valid=1, digest=ba7816bf...f20015ad, match=1, word_count=16, busy=0.
2. Mismatch: the same stream with expected digest bit 0 flipped -> digest_valid=1, match=0; with compare_enable=0 -> match=0.
3. Timeout: 5 words, then idle 64 cycles -> timeout_error=1 exactly TIMEOUT_CYCLES cycles after the last strobe, state ERROR, word_count=5, digest_valid=0; a later strobe sets overrun_error=1.
4. Gapped stream: 16 words each separated by 63 idle cycles -> no timeout, digest correct. A gap of 64 idle cycles -> timeout.
5. Overrun and clear: a 17th strobe after DONE -> overrun_error=1, digest unchanged. clear coinciding with a strobe -> all outputs 0, word_count=0, and the next stream captures correctly.
6. Reset mid-collection: async reset pulse after word 8, mid-cycle -> all outputs 0 immediately. A fresh 16-word stream (empty-string digest e3b0c442...7852b855) -> digest_valid=1, match=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host-side blocks: FSM encoding,
// digest width and known-answer digests.
package sha256_pkg;

  localparam int DIGEST_W = 256;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  // Digests of "abc" and of the empty message.
  localparam logic [DIGEST_W-1:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DIGEST_W-1:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  // Returns the idx-th 16-bit word of a digest, word 0 being the most significant.
  function automatic logic [15:0] digest_word(input logic [DIGEST_W-1:0] d, input int idx);
    return d[DIGEST_W-1-16*idx -: 16];
  endfunction

endpackage

// File: rtl/sha256_word_shifter.sv
// WORDS x WORD_W shift register; new words enter at the least significant end,
// so the first word captured ends up in the most significant slot.
module sha256_word_shifter
  import sha256_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int WORD_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WORD_W-1:0]         word_in,
  output logic [WORDS*WORD_W-1:0]   shifted,
  output logic [WORDS*WORD_W-1:0]   q
);

  // shifted is the value q would take on a load; the top compares against it.
  generate
    if (WORDS == 1) begin : g_single
      assign shifted = word_in;
    end else begin : g_multi
      assign shifted = {q[WORDS*WORD_W-WORD_W-1:0], word_in};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sha256_digest_collector.sv
// Collects the ASIC's 16-bit hash word stream into a 256-bit digest, optionally
// compares it to a reference, and flags inter-word timeouts and overruns.
module sha256_digest_collector
  import sha256_pkg::*;
#(
  parameter int WORDS          = 16,
  parameter int WORD_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    word_valid,
  input  logic [WORD_W-1:0]       word_data,
  input  logic                    compare_enable,
  input  logic [WORDS*WORD_W-1:0] expected_digest,
  input  logic                    clear,
  output logic [WORDS*WORD_W-1:0] digest,
  output logic                    digest_valid,
  output logic                    match,
  output logic                    busy,
  output logic [4:0]              word_count,
  output logic                    timeout_error,
  output logic                    overrun_error
);

  localparam int              GAP_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = '1;
  localparam logic [4:0]       LAST_CNT = 5'(WORDS - 1);

  logic [1:0]              state;
  logic [GAP_W-1:0]        gap_count;
  logic                    accepting;
  logic                    load;
  logic                    last_word;
  logic [WORDS*WORD_W-1:0] shifted;

  // Words are only taken while idle or collecting; clear always drops the strobe.
  always_comb begin
    accepting = (state == ST_IDLE) || (state == ST_COLLECT);
    load      = word_valid && accepting && !clear;
    last_word = load && (word_count == LAST_CNT);
  end

  sha256_word_shifter #(
    .WORDS  (WORDS),
    .WORD_W (WORD_W)
  ) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .load    (load),
    .word_in (word_data),
    .shifted (shifted),
    .q       (digest)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      gap_count     <= '0;
      word_count    <= '0;
      match         <= 1'b0;
      timeout_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (clear) begin
      state         <= ST_IDLE;
      gap_count     <= '0;
      word_count    <= '0;
      match         <= 1'b0;
      timeout_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (word_valid) begin
            word_count <= word_count + 5'd1;
            gap_count  <= '0;
            // The compare uses the digest as it will look after this capture.
            if (last_word) begin
              state <= ST_DONE;
              match <= compare_enable && (shifted == expected_digest);
            end else begin
              state <= ST_COLLECT;
            end
          end else if (state == ST_COLLECT) begin
            if (gap_count == GAP_LAST) begin
              state         <= ST_ERROR;
              timeout_error <= 1'b1;
            end else if (gap_count != GAP_MAX) begin
              gap_count <= gap_count + 1'b1;
            end
          end
        end
        default: begin
          if (word_valid) begin
            overrun_error <= 1'b1;
          end
        end
      endcase
    end
  end

  assign digest_valid = (state == ST_DONE);
  assign busy         = (state == ST_COLLECT);

endmodule

// File: tb/tb_sha256_digest_collector.sv
// Self-checking bench: directed scenarios plus random episodes, all checked
// every cycle against a queue-based reference of the collector's behaviour.
module tb_sha256_digest_collector;
  import sha256_pkg::*;

  localparam int WORDS   = 16;
  localparam int TIMEOUT = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         word_valid;
  logic [15:0]  word_data;
  logic         compare_enable;
  logic [255:0] expected_digest;
  logic         clear;
  logic [255:0] digest;
  logic         digest_valid;
  logic         match;
  logic         busy;
  logic [4:0]   word_count;
  logic         timeout_error;
  logic         overrun_error;

  int checks = 0;
  int errors = 0;

  // Reference: words captured so far, idle cycles since the last word, and a phase
  // (0 idle, 1 collecting, 2 complete, 3 timed out).
  logic [15:0] m_words[$];
  int          m_idle;
  int          m_phase;
  logic        m_match;
  logic        m_to;
  logic        m_ov;

  sha256_digest_collector dut (
    .clock           (clock),
    .reset           (reset),
    .word_valid      (word_valid),
    .word_data       (word_data),
    .compare_enable  (compare_enable),
    .expected_digest (expected_digest),
    .clear           (clear),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .match           (match),
    .busy            (busy),
    .word_count      (word_count),
    .timeout_error   (timeout_error),
    .overrun_error   (overrun_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] modelDigest();
    logic [255:0] d = '0;
    foreach (m_words[i]) d = (d << 16) | 256'(m_words[i]);
    return d;
  endfunction

  task automatic modelReset();
    m_words.delete();
    m_idle  = 0;
    m_phase = 0;
    m_match = 1'b0;
    m_to    = 1'b0;
    m_ov    = 1'b0;
  endtask

  task automatic modelStep(input logic wv, input logic [15:0] wd, input logic ce,
                           input logic [255:0] exp, input logic clr);
    if (clr) begin
      modelReset();
    end else if (m_phase == 0 || m_phase == 1) begin
      if (wv) begin
        m_words.push_back(wd);
        m_idle  = 0;
        m_phase = 1;
        if (m_words.size() == WORDS) begin
          m_phase = 2;
          m_match = ce && (modelDigest() == exp);
        end
      end else if (m_phase == 1) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_phase = 3;
          m_to    = 1'b1;
        end
      end
    end else if (wv) begin
      m_ov = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("digest", digest, modelDigest());
    checkOutput("digest_valid", 256'(digest_valid), 256'(m_phase == 2));
    checkOutput("busy", 256'(busy), 256'(m_phase == 1));
    checkOutput("word_count", 256'(word_count), 256'(m_words.size()));
    checkOutput("match", 256'(match), 256'(m_match));
    checkOutput("timeout_error", 256'(timeout_error), 256'(m_to));
    checkOutput("overrun_error", 256'(overrun_error), 256'(m_ov));
  endtask

  // One clock: drive on the falling edge, update the model on the rising edge, check 1ns later.
  task automatic applyStimulus(input logic wv, input logic [15:0] wd, input logic ce,
                               input logic [255:0] exp, input logic clr);
    @(negedge clock);
    word_valid      = wv;
    word_data       = wd;
    compare_enable  = ce;
    expected_digest = exp;
    clear           = clr;
    @(posedge clock);
    modelStep(wv, wd, ce, exp, clr);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n, input logic ce, input logic [255:0] exp);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'(i * 7), ce, exp, 1'b0);
  endtask

  task automatic sendDigest(input logic [255:0] d, input int nwords, input int gap,
                            input logic ce, input logic [255:0] exp);
    for (int i = 0; i < nwords; i++) begin
      applyStimulus(1'b1, digest_word(d, i), ce, exp, 1'b0);
      if (i < nwords - 1) idleCycles(gap, ce, exp);
    end
  endtask

  task automatic doClear(input logic wv);
    applyStimulus(wv, 16'hdead, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [255:0] randomDigest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [255:0] d;
    logic [255:0] held;
    int           n;
    int           gap;

    reset           = 1'b1;
    word_valid      = 1'b0;
    word_data       = '0;
    compare_enable  = 1'b0;
    expected_digest = '0;
    clear           = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    compareAll();
    @(negedge clock);
    reset = 1'b0;

    // Clean "abc" capture with compare.
    sendDigest(ABC_DIGEST, 16, 0, 1'b1, ABC_DIGEST);
    checkOutput("abc_digest", digest,
                256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    checkOutput("abc_match", 256'(match), 256'(1));
    doClear(1'b0);

    // Mismatching reference, then compare disabled.
    sendDigest(ABC_DIGEST, 16, 0, 1'b1, ABC_DIGEST ^ 256'd1);
    checkOutput("flip_match", 256'(match), 256'(0));
    doClear(1'b0);
    sendDigest(ABC_DIGEST, 16, 0, 1'b0, ABC_DIGEST);
    checkOutput("nocmp_match", 256'(match), 256'(0));
    doClear(1'b0);

    // Timeout after 5 words, then overrun while in error.
    d = randomDigest();
    sendDigest(d, 5, 0, 1'b1, d);
    idleCycles(TIMEOUT - 1, 1'b1, d);
    checkOutput("pre_timeout", 256'(timeout_error), 256'(0));
    idleCycles(1, 1'b1, d);
    checkOutput("timeout", 256'(timeout_error), 256'(1));
    checkOutput("timeout_count", 256'(word_count), 256'(5));
    applyStimulus(1'b1, 16'h1234, 1'b1, d, 1'b0);
    checkOutput("err_overrun", 256'(overrun_error), 256'(1));
    doClear(1'b0);

    // Gaps of 63 idle cycles are tolerated; 64 are not.
    sendDigest(ABC_DIGEST, 16, TIMEOUT - 1, 1'b1, ABC_DIGEST);
    checkOutput("gap63_match", 256'(match), 256'(1));
    doClear(1'b0);
    sendDigest(randomDigest(), 3, TIMEOUT, 1'b0, '0);
    checkOutput("gap64_timeout", 256'(timeout_error), 256'(1));
    doClear(1'b0);

    // Overrun after completion, clear racing a strobe, then a fresh capture.
    sendDigest(ABC_DIGEST, 16, 0, 1'b1, ABC_DIGEST);
    held = digest;
    applyStimulus(1'b1, 16'hffff, 1'b1, ABC_DIGEST, 1'b0);
    checkOutput("done_overrun", 256'(overrun_error), 256'(1));
    checkOutput("done_hold", digest, held);
    doClear(1'b1);
    checkOutput("clear_count", 256'(word_count), 256'(0));
    d = randomDigest();
    sendDigest(d, 16, 1, 1'b1, d);
    checkOutput("after_clear_match", 256'(match), 256'(1));
    doClear(1'b0);

    // Asynchronous reset in the middle of a cycle, mid-stream.
    sendDigest(ABC_DIGEST, 8, 0, 1'b1, ABC_DIGEST);
    #2;
    reset      = 1'b1;
    word_valid = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge clock);
    reset = 1'b0;
    sendDigest(EMPTY_DIGEST, 16, 0, 1'b1, EMPTY_DIGEST);
    checkOutput("empty_match", 256'(match), 256'(1));
    checkOutput("empty_valid", 256'(digest_valid), 256'(1));
    doClear(1'b0);

    // Random episodes: variable length, random gaps (occasionally past the timeout).
    for (int ep = 0; ep < 30; ep++) begin
      d = randomDigest();
      n = $urandom_range(1, 19);
      for (int i = 0; i < n; i++) begin
        applyStimulus(1'b1, (i < 16) ? digest_word(d, i) : 16'($urandom), ep[0],
                      ep[1] ? d : d ^ 256'd1, 1'b0);
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 3);
        idleCycles(gap, ep[0], ep[1] ? d : d ^ 256'd1);
      end
      doClear(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
